// File: rtl/scsi_xfer_sm_if.sv
// scsi_xfer_sm_if: SCSI-chip pins, DMA FIFO port and CPU-cycle handshake of the transfer sequencer.
// master = sequencer side, slave = chip/FIFO/CPU environment side.
interface scsi_xfer_sm_if #(
  parameter int WORD_BYTES = 4
);
  localparam int DW  = 8 * WORD_BYTES;
  localparam int BOW = $clog2(WORD_BYTES);

  logic           DMAENA;
  logic           DMADIR;
  logic           CCPUREQ;
  logic           CDREQ_;
  logic           CDSACK_;
  logic           FIFOFULL;
  logic           FIFOEMPTY;
  logic [DW-1:0]  FIFO_RD_DATA;
  logic [7:0]     SCSI_DIN;
  logic           FLUSH;
  logic           CDACK_;
  logic           CCS_;
  logic           SCSI_RE_;
  logic           SCSI_WE_;
  logic [7:0]     SCSI_DOUT;
  logic           DOE;
  logic [DW-1:0]  FIFO_WR_DATA;
  logic           INCFIFO;
  logic           DECFIFO;
  logic           CPU_ACK;
  logic           BERR;
  logic           FLUSH_DONE;
  logic [BOW-1:0] BO;

  modport master (
    input  DMAENA, DMADIR, CCPUREQ, CDREQ_, CDSACK_, FIFOFULL, FIFOEMPTY,
           FIFO_RD_DATA, SCSI_DIN, FLUSH,
    output CDACK_, CCS_, SCSI_RE_, SCSI_WE_, SCSI_DOUT, DOE, FIFO_WR_DATA,
           INCFIFO, DECFIFO, CPU_ACK, BERR, FLUSH_DONE, BO
  );

  modport slave (
    output DMAENA, DMADIR, CCPUREQ, CDREQ_, CDSACK_, FIFOFULL, FIFOEMPTY,
           FIFO_RD_DATA, SCSI_DIN, FLUSH,
    input  CDACK_, CCS_, SCSI_RE_, SCSI_WE_, SCSI_DOUT, DOE, FIFO_WR_DATA,
           INCFIFO, DECFIFO, CPU_ACK, BERR, FLUSH_DONE, BO
  );
endinterface

// File: rtl/scsi_xfer_sm.sv
// scsi_xfer_sm: CPU/DMA arbiter and CDREQ_/CDACK_ byte sequencer packing bytes to/from FIFO words; SCSI_TIMEOUT_EN adds a CPU watchdog.
// Latency STROBE_CYCLES+3 cycles per byte; waits in IDLE on FIFOFULL (fill) or FIFOEMPTY at lane 0 (drain); CPU cycles wait on CDSACK_.
module scsi_xfer_sm #(
  parameter int WORD_BYTES     = 4,
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           CPUCLK,
  input  logic           RESET,
  scsi_xfer_sm_if.master bus
);
  localparam int              BOW      = $clog2(WORD_BYTES);
  localparam int              DW       = 8 * WORD_BYTES;
  localparam logic [BOW-1:0]  BO_MAX   = BOW'(WORD_BYTES - 1);
  localparam logic [3:0]      STB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [7:0]      WD_LAST  = 8'(TIMEOUT_CYCLES - 1);
`ifdef SCSI_TIMEOUT_EN
  localparam bit              WD_EN    = 1'b1;
`else
  localparam bit              WD_EN    = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, CPU_CS, CPU_END, DMA_STB, DMA_REL, RECOVER, FLUSH_PUSH
  } state_t;

  state_t         state_q, state_d;
  logic [BOW-1:0] bo_q, bo_d;
  logic           dir_q, dir_d;
  logic [DW-1:0]  pack_q, pack_d;
  logic [DW-1:0]  hold_q, hold_d;
  logic [3:0]     stb_q, stb_d;
  logic [7:0]     wd_q, wd_d;
  logic           ack_q, ack_d;
  logic           berr_q, berr_d;
  logic           dec_q, dec_d;
  logic           fdone_q, fdone_d;
  logic           flush_q, flush_d;
  logic           eff_dir, dma_go, flush_req;
  logic [BOW+2:0] lane_lsb;

  // Lane 0 is the most significant byte of the word.
  assign lane_lsb  = {BO_MAX - bo_q, 3'b000};
  // Direction only re-latches on a word boundary; mid-word bytes keep the old one.
  assign eff_dir   = (bo_q == '0) ? bus.DMADIR : dir_q;
  assign dma_go    = bus.DMAENA && !bus.CDREQ_ &&
                     (eff_dir ? !bus.FIFOFULL : (bo_q != '0 || !bus.FIFOEMPTY));
  assign flush_req = flush_q || bus.FLUSH;

  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      state_q <= IDLE;
      bo_q    <= '0;
      dir_q   <= 1'b0;
      pack_q  <= '0;
      hold_q  <= '0;
      stb_q   <= '0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
      dec_q   <= 1'b0;
      fdone_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bo_q    <= bo_d;
      dir_q   <= dir_d;
      pack_q  <= pack_d;
      hold_q  <= hold_d;
      stb_q   <= stb_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      berr_q  <= berr_d;
      dec_q   <= dec_d;
      fdone_q <= fdone_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bo_d    = bo_q;
    dir_d   = dir_q;
    pack_d  = pack_q;
    hold_d  = hold_q;
    stb_d   = '0;
    wd_d    = '0;
    ack_d   = 1'b0;
    berr_d  = 1'b0;
    dec_d   = 1'b0;
    fdone_d = 1'b0;
    flush_d = flush_req;
    case (state_q)
      IDLE: begin
        if (bus.CCPUREQ) begin
          state_d = CPU_CS;
        end else if (flush_req) begin
          if (!bus.FIFOFULL) begin
            flush_d = 1'b0;
            if (dir_q && bo_q != '0) begin
              state_d = FLUSH_PUSH;
            end else begin
              fdone_d = 1'b1;
              bo_d    = '0;
              if (!dir_q) hold_d = '0;
            end
          end
        end else if (dma_go) begin
          state_d = DMA_STB;
          dir_d   = eff_dir;
          if (!eff_dir && bo_q == '0) begin
            hold_d = bus.FIFO_RD_DATA;
            dec_d  = 1'b1;
          end
        end
      end
      CPU_CS: begin
        wd_d = wd_q + 8'd1;
        if (!bus.CDSACK_) begin
          state_d = CPU_END;
          ack_d   = 1'b1;
        end else if (WD_EN && wd_q == WD_LAST) begin
          state_d = CPU_END;
          ack_d   = 1'b1;
          berr_d  = 1'b1;
        end
      end
      CPU_END: begin
        if (!bus.CCPUREQ) state_d = IDLE;
      end
      DMA_STB: begin
        stb_d = stb_q + 4'd1;
        if (stb_q == STB_LAST) begin
          stb_d   = '0;
          state_d = DMA_REL;
          if (dir_q) pack_d[lane_lsb +: 8] = bus.SCSI_DIN;
        end
      end
      DMA_REL: begin
        state_d = RECOVER;
        if (bo_q == BO_MAX) begin
          bo_d = '0;
          // Clearing after the push keeps unwritten lanes zero for a later flush.
          if (dir_q) pack_d = '0;
        end else begin
          bo_d = bo_q + 1'b1;
        end
      end
      RECOVER: state_d = IDLE;
      FLUSH_PUSH: begin
        state_d = IDLE;
        bo_d    = '0;
        pack_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.CCS_         = (state_q != CPU_CS);
  assign bus.CDACK_       = (state_q != DMA_STB);
  assign bus.SCSI_RE_     = !(state_q == DMA_STB && dir_q);
  assign bus.SCSI_WE_     = !(state_q == DMA_STB && !dir_q);
  assign bus.DOE          = (state_q == DMA_STB) && !dir_q;
  assign bus.SCSI_DOUT    = hold_q[lane_lsb +: 8];
  assign bus.FIFO_WR_DATA = pack_q;
  assign bus.INCFIFO      = (state_q == DMA_REL && dir_q && bo_q == BO_MAX) ||
                            (state_q == FLUSH_PUSH);
  assign bus.DECFIFO      = dec_q;
  assign bus.CPU_ACK      = ack_q;
  assign bus.BERR         = berr_q;
  assign bus.FLUSH_DONE   = fdone_q || (state_q == FLUSH_PUSH);
  assign bus.BO           = bo_q;
endmodule

// File: tb/tb_scsi_xfer_sm.sv
// Bench for scsi_xfer_sm: a 4-byte-word fill/flush/CPU instance and a 2-byte-word drain instance,
// random bytes and words checked against byte-order arithmetic.
module tb_scsi_xfer_sm;
  logic CPUCLK = 1'b0;
  logic RESET;
  always #5 CPUCLK = ~CPUCLK;

  scsi_xfer_sm_if #(.WORD_BYTES(4)) b4 ();
  scsi_xfer_sm_if #(.WORD_BYTES(2)) b2 ();

  scsi_xfer_sm #(.WORD_BYTES(4), .STROBE_CYCLES(2), .TIMEOUT_CYCLES(16)) u4 (
    .CPUCLK(CPUCLK), .RESET(RESET), .bus(b4));
  scsi_xfer_sm #(.WORD_BYTES(2), .STROBE_CYCLES(3), .TIMEOUT_CYCLES(255)) u2 (
    .CPUCLK(CPUCLK), .RESET(RESET), .bus(b2));

  int n_pass = 0;
  int n_chk  = 0;
  int inc4   = 0;
  int fd4    = 0;
  int dec2   = 0;
  logic [31:0] wr4_q[$];

  always @(negedge CPUCLK) begin
    if (b4.INCFIFO === 1'b1) begin
      inc4++;
      wr4_q.push_back(b4.FIFO_WR_DATA);
    end
    if (b4.FLUSH_DONE === 1'b1) fd4++;
    if (b2.DECFIFO === 1'b1) dec2++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge CPUCLK);
    #1;
  endtask

  task automatic byte4(input logic [7:0] din);
    int n;
    int len;
    b4.SCSI_DIN = din;
    b4.CDREQ_   = 1'b0;
    n = 0;
    while (b4.CDACK_ !== 1'b0 && n < 20) begin tick(); n++; end
    chk("fill_ack_seen", 32'(n < 20), 32'd1);
    b4.CDREQ_ = 1'b1;
    len = 0;
    while (b4.CDACK_ === 1'b0 && len < 20) begin
      if (b4.SCSI_RE_ === 1'b0) len++;
      tick();
    end
    chk("fill_strobe_len", 32'(len), 32'd2);
    b4.SCSI_DIN = 8'($urandom);
    tick();
    tick();
  endtask

  task automatic byte2(output logic [7:0] dout);
    int n;
    int len;
    dout      = 8'h00;
    b2.CDREQ_ = 1'b0;
    n = 0;
    while (b2.CDACK_ !== 1'b0 && n < 20) begin tick(); n++; end
    chk("drain_ack_seen", 32'(n < 20), 32'd1);
    b2.CDREQ_ = 1'b1;
    len = 0;
    while (b2.CDACK_ === 1'b0 && len < 20) begin
      if (b2.SCSI_WE_ === 1'b0 && b2.DOE === 1'b1) begin
        if (len == 0) dout = b2.SCSI_DOUT;
        len++;
      end
      tick();
    end
    chk("drain_strobe_len", 32'(len), 32'd3);
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] expw;
    logic [31:0] gotw;
    logic [15:0] word;
    logic [7:0]  b;
    logic [7:0]  got;
    int          i0;
    int          f0;
    int          d0;
    int          n;

    RESET = 1'b1;
    b4.DMAENA = 1'b0; b4.DMADIR = 1'b0; b4.CCPUREQ = 1'b0; b4.CDREQ_ = 1'b1; b4.CDSACK_ = 1'b1;
    b4.FIFOFULL = 1'b0; b4.FIFOEMPTY = 1'b1; b4.FIFO_RD_DATA = '0; b4.SCSI_DIN = '0; b4.FLUSH = 1'b0;
    b2.DMAENA = 1'b0; b2.DMADIR = 1'b0; b2.CCPUREQ = 1'b0; b2.CDREQ_ = 1'b1; b2.CDSACK_ = 1'b1;
    b2.FIFOFULL = 1'b0; b2.FIFOEMPTY = 1'b1; b2.FIFO_RD_DATA = '0; b2.SCSI_DIN = '0; b2.FLUSH = 1'b0;
    tick();
    tick();
    chk("rst_u4_ctl", 32'({b4.CDACK_, b4.CCS_, b4.SCSI_RE_, b4.SCSI_WE_, b4.DOE, b4.INCFIFO,
                           b4.DECFIFO, b4.CPU_ACK, b4.BERR, b4.FLUSH_DONE}), 32'h3C0);
    chk("rst_u4_bo", 32'(b4.BO), 32'd0);
    chk("rst_u4_wr", b4.FIFO_WR_DATA, 32'd0);
    chk("rst_u2_ctl", 32'({b2.CDACK_, b2.CCS_, b2.SCSI_WE_, b2.DOE, b2.DECFIFO}), 32'h1C);
    RESET = 1'b0;
    tick();

    // Fill: full FIFO blocks a byte start.
    b4.DMAENA = 1'b1; b4.DMADIR = 1'b1; b4.FIFOFULL = 1'b1; b4.CDREQ_ = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (b4.CDACK_ === 1'b0) n++; end
    chk("fill_full_blocks", 32'(n), 32'd0);
    b4.CDREQ_ = 1'b1; b4.FIFOFULL = 1'b0;
    tick();

    for (int w = 0; w < 4; w++) begin
      expw = '0;
      i0   = inc4;
      for (int i = 0; i < 4; i++) begin
        b = (w == 0) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
        byte4(b);
        expw = (expw << 8) | 32'(b);
        chk("fill_bo", 32'(b4.BO), 32'((i + 1) % 4));
      end
      chk("fill_inc_count", 32'(inc4 - i0), 32'd1);
      gotw = (wr4_q.size() != 0) ? wr4_q.pop_front() : 32'hDEADBEEF;
      chk("fill_word", gotw, expw);
    end

    // Flush partial words of 2 and 3 bytes: zero padding in the low lanes.
    for (int t = 0; t < 2; t++) begin
      expw = '0;
      for (int i = 0; i < t + 2; i++) begin
        b = (t == 0) ? 8'(i + 1) : 8'($urandom);
        byte4(b);
        expw = expw | (32'(b) << (8 * (3 - i)));
      end
      i0 = inc4; f0 = fd4;
      b4.FLUSH = 1'b1;
      tick();
      b4.FLUSH = 1'b0;
      tick();
      chk("flush_inc", 32'(inc4 - i0), 32'd1);
      chk("flush_done", 32'(fd4 - f0), 32'd1);
      gotw = (wr4_q.size() != 0) ? wr4_q.pop_front() : 32'hDEADBEEF;
      chk("flush_word", gotw, expw);
      chk("flush_bo", 32'(b4.BO), 32'd0);
    end

    // Flush on a word boundary: done, no push.
    i0 = inc4; f0 = fd4;
    b4.FLUSH = 1'b1;
    tick();
    b4.FLUSH = 1'b0;
    tick();
    chk("flush_empty_noinc", 32'(inc4 - i0), 32'd0);
    chk("flush_empty_done", 32'(fd4 - f0), 32'd1);

    // Flush held off by a full FIFO.
    b = 8'($urandom);
    byte4(b);
    i0 = inc4; f0 = fd4;
    b4.FIFOFULL = 1'b1; b4.FLUSH = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("flush_full_held", 32'(fd4 - f0 + inc4 - i0), 32'd0);
    chk("flush_full_bo", 32'(b4.BO), 32'd1);
    b4.FIFOFULL = 1'b0;
    tick();
    b4.FLUSH = 1'b0;
    tick();
    chk("flush_rel_inc", 32'(inc4 - i0), 32'd1);
    gotw = (wr4_q.size() != 0) ? wr4_q.pop_front() : 32'hDEADBEEF;
    chk("flush_rel_word", gotw, 32'(b) << 24);

    // Drain: one pop per word, bytes leave most significant first.
    b2.DMAENA = 1'b1; b2.DMADIR = 1'b0;
    for (int w = 0; w < 4; w++) begin
      word = (w == 0) ? 16'hA55A : 16'($urandom);
      b2.FIFO_RD_DATA = word; b2.FIFOEMPTY = 1'b0;
      d0 = dec2;
      for (int i = 0; i < 2; i++) begin
        byte2(got);
        b2.FIFOEMPTY = 1'b1;
        b2.FIFO_RD_DATA = 16'($urandom);
        chk("drain_byte", 32'(got), 32'((word >> (8 * (1 - i))) & 16'h00FF));
      end
      chk("drain_dec_count", 32'(dec2 - d0), 32'd1);
    end
    b2.CDREQ_ = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (b2.CDACK_ === 1'b0) n++; end
    chk("drain_empty_blocks", 32'(n), 32'd0);
    b2.CDREQ_ = 1'b1;
    tick();

    // Arbitration: CPU wins a simultaneous request, DMA follows CPU_END.
    byte4(8'($urandom));
    b4.CCPUREQ = 1'b1; b4.CDREQ_ = 1'b0;
    tick();
    chk("arb_ccs_first", 32'({b4.CCS_, b4.CDACK_}), 32'b01);
    b4.CDSACK_ = 1'b0;
    tick();
    chk("arb_cpu_ack", 32'({b4.CPU_ACK, b4.CCS_, b4.BERR}), 32'b110);
    b4.CDSACK_ = 1'b1; b4.CCPUREQ = 1'b0;
    tick();
    chk("arb_ack_once", 32'({b4.CPU_ACK, b4.CDACK_}), 32'b01);
    tick();
    chk("arb_dma_after", 32'({b4.CDACK_, b4.SCSI_RE_}), 32'b00);

    // Reset in the middle of the strobe.
    RESET = 1'b1;
    tick();
    chk("rst_mid_strobe", 32'({b4.CDACK_, b4.SCSI_RE_, b4.INCFIFO}), 32'b110);
    chk("rst_mid_bo", 32'(b4.BO), 32'd0);
    tick();
    RESET = 1'b0; b4.CDREQ_ = 1'b1;
    tick();

    // CPU cycle with CDSACK_ never answering.
    b4.CDSACK_ = 1'b1; b4.CCPUREQ = 1'b1;
    tick();
    n = 0;
    while (b4.CCS_ === 1'b0 && n < 40) begin n++; tick(); end
`ifdef SCSI_TIMEOUT_EN
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_berr_ack", 32'({b4.BERR, b4.CPU_ACK, b4.CCS_}), 32'b111);
    b4.CCPUREQ = 1'b0;
    tick();
    chk("to_berr_once", 32'(b4.BERR), 32'd0);
`else
    chk("to_wait_forever", 32'(n), 32'd40);
    chk("to_no_berr", 32'(b4.BERR), 32'd0);
    b4.CDSACK_ = 1'b0;
    tick();
    chk("to_late_ack", 32'({b4.CPU_ACK, b4.BERR}), 32'b10);
    b4.CDSACK_ = 1'b1; b4.CCPUREQ = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
